// File: rtl/wb_demux32.sv
// wb_demux32: write-back stage register plus destination decode.
// Holds one write-back request per cycle and fans it out as a one-hot
// per-register write enable, registered write data and two forwarding
// hit flags. Register index ZERO_REG is hardwired to zero, so it is never
// enabled and never forwarded.
//
// Handshake: valid_out qualifies addr_out/data_out/en_onehot. There is no
// ready: the register file always accepts a live write in the same cycle,
// so a request captured on edge N is consumed during the cycle after N.
// stall holds the stage; flush kills the held write (flush wins over stall).
module wb_demux32 #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    fwd_addr_a,
    input  logic [ADDR_W-1:0]    fwd_addr_b,
    output logic [2**ADDR_W-1:0] en_onehot,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    output logic [ADDR_W-1:0]    addr_out,
    output logic                 fwd_hit_a,
    output logic                 fwd_hit_b
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // A held write that really lands in the register file (not the zero reg).
    logic w_live;

    // Stage register: flush kills, stall holds, otherwise capture unconditionally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid <= wr_en;
            r_addr  <= wr_addr;
            r_data  <= wr_data;
        end
    end

    assign w_live = r_valid && (r_addr != ZERO_IDX);

    // One-hot decode of the held destination; decoded only from registered state.
    always_comb begin
        en_onehot = '0;
        if (w_live) begin
            en_onehot = NUM_REGS'(1) << r_addr;
        end
    end

    // Forwarding compare against the read-port source indices, same cycle.
    always_comb begin
        fwd_hit_a = w_live && (r_addr == fwd_addr_a);
        fwd_hit_b = w_live && (r_addr == fwd_addr_b);
    end

    assign data_out  = r_data;
    assign addr_out  = r_addr;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_wb_demux32.sv
// Directed bench for wb_demux32: reset, decode sweep, stall/flush,
// unqualified capture, forwarding and asynchronous reset.
module tb_wb_demux32;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        stall;
    logic        flush;
    logic [4:0]  fwd_addr_a;
    logic [4:0]  fwd_addr_b;
    logic [31:0] en_onehot;
    logic [63:0] data_out;
    logic        valid_out;
    logic [4:0]  addr_out;
    logic        fwd_hit_a;
    logic        fwd_hit_b;

    int n_vec;
    int n_err;

    wb_demux32 #(.ADDR_W(5), .DATA_W(64), .ZERO_REG(31)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .stall      (stall),
        .flush      (flush),
        .fwd_addr_a (fwd_addr_a),
        .fwd_addr_b (fwd_addr_b),
        .en_onehot  (en_onehot),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .addr_out   (addr_out),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [4:0] a, input logic [63:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n    = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        fwd_addr_a = 5'd0;
        fwd_addr_b = 5'd0;
        drive(1'b1, 5'd5, 64'hDEAD);

        // Reset held with clocks running and a request on the inputs.
        #1;
        chk("rst_valid_t0", {63'd0, valid_out}, 64'd0);
        chk("rst_en_t0", {32'd0, en_onehot}, 64'd0);
        chk("rst_data_t0", data_out, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_valid", {63'd0, valid_out}, 64'd0);
            chk("rst_en", {32'd0, en_onehot}, 64'd0);
            chk("rst_data", data_out, 64'd0);
        end
        reset_n = 1'b1;
        step();
        chk("rel_en", {32'd0, en_onehot}, 64'h0000_0020);
        chk("rel_data", data_out, 64'hDEAD);
        chk("rel_valid", {63'd0, valid_out}, 64'd1);

        // Decode sweep over every index.
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 64'(a) * 64'h1111);
            step();
            chk("sweep_en", {32'd0, en_onehot}, (a == 31) ? 64'd0 : (64'd1 << a));
            chk("sweep_data", data_out, 64'(a) * 64'h1111);
            chk("sweep_valid", {63'd0, valid_out}, 64'd1);
        end

        // Stall holds, then stall+flush kills but keeps address/data.
        drive(1'b1, 5'd7, 64'h77);
        step();
        chk("load7_en", {32'd0, en_onehot}, 64'h80);
        stall = 1'b1;
        drive(1'b1, 5'd9, 64'h99);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_en", {32'd0, en_onehot}, 64'h80);
            chk("stall_data", data_out, 64'h77);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, valid_out}, 64'd0);
        chk("flush_en", {32'd0, en_onehot}, 64'd0);
        chk("flush_addr", {59'd0, addr_out}, 64'd7);
        chk("flush_data", data_out, 64'h77);
        stall = 1'b0;
        flush = 1'b0;

        // Capture without wr_en: address/data follow, outputs gated off.
        drive(1'b0, 5'd3, 64'h33);
        fwd_addr_a = 5'd3;
        fwd_addr_b = 5'd3;
        step();
        chk("noen_valid", {63'd0, valid_out}, 64'd0);
        chk("noen_en", {32'd0, en_onehot}, 64'd0);
        chk("noen_addr", {59'd0, addr_out}, 64'd3);
        chk("noen_data", data_out, 64'h33);
        chk("noen_hit_a", {63'd0, fwd_hit_a}, 64'd0);
        chk("noen_hit_b", {63'd0, fwd_hit_b}, 64'd0);

        // Forwarding: both ports hit, then port B moves away mid-cycle.
        drive(1'b1, 5'd12, 64'hC0C0);
        step();
        fwd_addr_a = 5'd12;
        fwd_addr_b = 5'd12;
        #1;
        chk("fwd_hit_a12", {63'd0, fwd_hit_a}, 64'd1);
        chk("fwd_hit_b12", {63'd0, fwd_hit_b}, 64'd1);
        fwd_addr_b = 5'd13;
        #1;
        chk("fwd_hit_b13", {63'd0, fwd_hit_b}, 64'd0);
        chk("fwd_hit_a_keep", {63'd0, fwd_hit_a}, 64'd1);

        // Zero register: live but neither enabled nor forwarded.
        drive(1'b1, 5'd31, 64'h3131);
        fwd_addr_a = 5'd31;
        step();
        chk("zr_hit_a", {63'd0, fwd_hit_a}, 64'd0);
        chk("zr_valid", {63'd0, valid_out}, 64'd1);
        chk("zr_en", {32'd0, en_onehot}, 64'd0);
        chk("zr_addr", {59'd0, addr_out}, 64'd31);

        // Asynchronous reset between edges clears a live write immediately.
        drive(1'b1, 5'd4, 64'h44);
        step();
        chk("ar_en_before", {32'd0, en_onehot}, 64'h10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_en", {32'd0, en_onehot}, 64'd0);
        chk("ar_valid", {63'd0, valid_out}, 64'd0);
        chk("ar_data", data_out, 64'd0);
        chk("ar_addr", {59'd0, addr_out}, 64'd0);
        #1;
        reset_n = 1'b1;
        step();
        chk("ar_recover_en", {32'd0, en_onehot}, 64'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
